// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: stages, opcodes,
// ALU function codes and datapath mux selects.
package rv32_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_FETCH     = 5'd0,
        ST_DECODE    = 5'd1,
        ST_EXECUTE   = 5'd2,
        ST_MEMORY    = 5'd3,
        ST_WRITEBACK = 5'd4,
        ST_HALT      = 5'd5
    } stage_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    // Tells the ALU decoder how to interpret funct3/funct7_5 this cycle.
    typedef enum logic [2:0] {
        CLS_ADD, CLS_REG, CLS_IMM, CLS_BRANCH, CLS_LUI
    } op_class_e;

    localparam logic [1:0] MTOR_ALU     = 2'b00;
    localparam logic [1:0] MTOR_MEM     = 2'b01;
    localparam logic [1:0] MTOR_PC4     = 2'b10;
    localparam logic [1:0] SRCB_RSB     = 2'b00;
    localparam logic [1:0] SRCB_IMM     = 2'b01;
    localparam logic [1:0] SRCB_FOUR    = 2'b10;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    // SYSTEM, FENCE and any unlisted opcode are illegal, as are the two unused branch funct3 codes.
    function automatic logic is_legal_op(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
            OP_BRANCH:                 return !(f3 == 3'b010 || f3 == 3'b011);
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the main FSM (master) and the IR/ALU/memory datapath (slave).
interface multicycle_control_fsm_if;
    import rv32_ctrl_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic [4:0] current_stage;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] MtoR;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] PCSrc;
    alu_op_e    alu_op;
    logic       instr_retired;
    logic       illegal_instr;
    logic       bus_error;

    modport master (
        input  opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
        output current_stage, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
               MtoR, AluSrcA, AluSrcB, PCSrc, alu_op, instr_retired,
               illegal_instr, bus_error
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
        input  current_stage, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
               MtoR, AluSrcA, AluSrcB, PCSrc, alu_op, instr_retired,
               illegal_instr, bus_error
    );

endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU function decode from the instruction class and funct fields.
module alu_decoder
    import rv32_ctrl_pkg::*;
(
    input  op_class_e  op_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_e    alu_op
);

    // funct7_5 selects SUB only for register-register ops; ADDI ignores it, shifts honour it in both forms.
    always_comb begin
        alu_op = ALU_ADD;
        case (op_class)
            CLS_REG, CLS_IMM: begin
                case (funct3)
                    3'b000: alu_op = (op_class == CLS_REG && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                endcase
            end
            CLS_BRANCH: alu_op = ALU_SUB;
            CLS_LUI:    alu_op = ALU_PASS_B;
            default:    alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and guards memory waits with a timeout.
module multicycle_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_control_fsm_if.master bus
);

    stage_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;

    logic               pc_write, ir_write, mem_read, mem_write, reg_write, retired;
    logic [1:0]         mto_r, src_b, pc_src;
    logic               src_a;
    logic               taken;
    logic               timeout_hit;
    logic               is_load;
    op_class_e          op_class;
    alu_op_e            alu_op_dec;

    alu_decoder u_alu_dec (
        .op_class (op_class),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .alu_op   (alu_op_dec)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT));
    assign is_load     = (bus.opcode == OP_LOAD);

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = !bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    // Outputs are forced to their idle values while reset is held so an aborted
    // instruction can never leave a RegWrite/MemWrite behind.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        retired    = 1'b0;
        mto_r      = MTOR_ALU;
        src_a      = 1'b0;
        src_b      = SRCB_RSB;
        pc_src     = PCSRC_ALU;
        op_class   = CLS_ADD;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    src_b    = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (timeout_hit) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    src_b = SRCB_IMM;
                    if (!is_legal_op(bus.opcode, bus.funct3)) begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        state_d = ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    state_d = ST_WRITEBACK;
                    case (bus.opcode)
                        OP_R: begin
                            src_a    = 1'b1;
                            op_class = CLS_REG;
                        end
                        OP_IMM: begin
                            src_a    = 1'b1;
                            src_b    = SRCB_IMM;
                            op_class = CLS_IMM;
                        end
                        OP_LOAD, OP_STORE: begin
                            src_a      = 1'b1;
                            src_b      = SRCB_IMM;
                            wait_cnt_d = '0;
                            state_d    = ST_MEMORY;
                        end
                        OP_LUI: begin
                            src_b    = SRCB_IMM;
                            op_class = CLS_LUI;
                        end
                        OP_AUIPC: src_b = SRCB_IMM;
                        OP_BRANCH: begin
                            src_a      = 1'b1;
                            op_class   = CLS_BRANCH;
                            pc_write   = taken;
                            pc_src     = PCSRC_ALUOUT;
                            retired    = 1'b1;
                            wait_cnt_d = '0;
                            state_d    = ST_FETCH;
                        end
                        OP_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = PCSRC_ALUOUT;
                        end
                        OP_JALR: begin
                            src_a    = 1'b1;
                            src_b    = SRCB_IMM;
                            pc_write = 1'b1;
                            pc_src   = PCSRC_JALR;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = ST_HALT;
                        end
                    endcase
                end
                ST_MEMORY: begin
                    mem_read  = is_load;
                    mem_write = !is_load;
                    if (bus.mem_ready) begin
                        if (is_load) begin
                            state_d = ST_WRITEBACK;
                        end else begin
                            retired    = 1'b1;
                            wait_cnt_d = '0;
                            state_d    = ST_FETCH;
                        end
                    end else if (timeout_hit) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_WRITEBACK: begin
                    reg_write  = 1'b1;
                    retired    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_FETCH;
                    if (is_load) begin
                        mto_r = MTOR_MEM;
                    end else if (bus.opcode == OP_JAL || bus.opcode == OP_JALR) begin
                        mto_r = MTOR_PC4;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.current_stage = state_q;
    assign bus.PCWrite       = pc_write;
    assign bus.IRWrite       = ir_write;
    assign bus.MemRead       = mem_read;
    assign bus.MemWrite      = mem_write;
    assign bus.RegWrite      = reg_write;
    assign bus.MtoR          = mto_r;
    assign bus.AluSrcA       = src_a;
    assign bus.AluSrcB       = src_b;
    assign bus.PCSrc         = pc_src;
    assign bus.alu_op        = alu_op_dec;
    assign bus.instr_retired = retired;
    assign bus.illegal_instr = illegal_q;
    assign bus.bus_error     = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle control FSM: each instruction is expanded
// into its expected per-cycle schedule and compared against the DUT every cycle.
module tb_multicycle_control_fsm;
    import rv32_ctrl_pkg::*;

    localparam int TMO = 4;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct {
        int         stage;
        logic       pcw, irw, mr, mw, rw, ret, ill, berr;
        logic       care_a, care_b, care_mtor, care_pcsrc, care_alu;
        logic       a;
        logic [1:0] b, mtor, pcsrc;
        alu_op_e    alu;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t  exp_q[$];
    exp_t  sched_q[$];
    logic  rdy_q[$];
    exp_t  cur;
    string cur_name = "init";
    int    total = 0, bad = 0;
    int    cyc_cnt = 0, last_cpi = 0, sched_len = 0;

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s/%s: got %0d, expected %0d", cur_name, name, act, req);
        end
    endtask

    function automatic exp_t base(input int stage);
        exp_t e;
        e.stage = stage;
        e.pcw = 0; e.irw = 0; e.mr = 0; e.mw = 0; e.rw = 0; e.ret = 0; e.ill = 0; e.berr = 0;
        e.care_a = 0; e.care_b = 0; e.care_mtor = 0; e.care_pcsrc = 0; e.care_alu = 0;
        e.a = 0; e.b = 2'b00; e.mtor = 2'b00; e.pcsrc = 2'b00; e.alu = ALU_ADD;
        return e;
    endfunction

    function automatic alu_op_e expAlu(input logic [2:0] f3, input logic f75, input bit reg_form);
        case (f3)
            3'd0:    return (reg_form && f75) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f75 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic bit expTaken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 0;
        endcase
    endfunction

    function automatic bit expLegal(input logic [6:0] op, input logic [2:0] f3);
        if (op == OPC_BRANCH) return (f3 != 3'd2 && f3 != 3'd3);
        return op inside {OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

    task automatic pushCycle(input exp_t e, input logic rdy);
        sched_q.push_back(e);
        rdy_q.push_back(rdy);
    endtask

    task automatic haltCycles(input logic ill, input logic berr);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e = base(5);
            e.ill = ill;
            e.berr = berr;
            pushCycle(e, 1'b1);
        end
    endtask

    // A request phase: 'waits' cycles without mem_ready, then one with it, unless the
    // wait count reaches TMO first with mem_ready still low, which is a bus error.
    task automatic reqPhase(input int stage, input int waits, input bit is_write,
                            input bit retire_done, output bit timed_out);
        exp_t e;
        timed_out = 0;
        for (int j = 0; j <= waits; j++) begin
            e = base(stage);
            e.mr = !is_write;
            e.mw = is_write;
            if (stage == 0) begin
                e.care_a = 1; e.care_b = 1; e.b = 2'b10; e.care_alu = 1;
            end
            if (j == waits) begin
                if (stage == 0) begin
                    e.irw = 1; e.pcw = 1; e.care_pcsrc = 1;
                end
                e.ret = retire_done;
                pushCycle(e, 1'b1);
            end else begin
                pushCycle(e, 1'b0);
                if (j == TMO) begin
                    timed_out = 1;
                    haltCycles(1'b0, 1'b1);
                    break;
                end
            end
        end
    endtask

    // cut > 0 drives only that many cycles and returns mid-cycle in the last one.
    task automatic applyStimulus(input string name, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f75, input logic [2:0] zll, input int fwait,
                                 input int mwait, input int cut);
        exp_t e;
        bit   to, done, is_ld, is_st;
        int   n;
        cur_name = name;
        sched_q.delete();
        rdy_q.delete();
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7_5 = f75;
        {bus.zero, bus.lt, bus.ltu} = zll;
        is_ld = (op == OPC_LOAD);
        is_st = (op == OPC_STORE);
        reqPhase(0, fwait, 0, 0, to);
        done = to;
        if (!done) begin
            e = base(1);
            e.care_a = 1; e.care_b = 1; e.b = 2'b01; e.care_alu = 1;
            pushCycle(e, 1'b1);
            if (!expLegal(op, f3)) begin
                haltCycles(1'b1, 1'b0);
                done = 1;
            end
        end
        if (!done) begin
            e = base(2);
            e.care_a = 1; e.care_b = 1; e.care_alu = 1;
            case (op)
                OPC_R:      begin e.a = 1; e.b = 2'b00; e.alu = expAlu(f3, f75, 1); end
                OPC_I:      begin e.a = 1; e.b = 2'b01; e.alu = expAlu(f3, f75, 0); end
                OPC_LOAD, OPC_STORE: begin e.a = 1; e.b = 2'b01; end
                OPC_LUI:    begin e.care_a = 0; e.b = 2'b01; e.alu = ALU_PASS_B; end
                OPC_AUIPC:  begin e.a = 0; e.b = 2'b01; end
                OPC_BRANCH: begin
                    e.a = 1; e.b = 2'b00; e.alu = ALU_SUB; e.ret = 1;
                    e.pcw = expTaken(f3, zll[2], zll[1], zll[0]);
                    e.care_pcsrc = e.pcw; e.pcsrc = 2'b01;
                    done = 1;
                end
                OPC_JAL:    begin e.care_a = 0; e.care_b = 0; e.care_alu = 0;
                                  e.pcw = 1; e.care_pcsrc = 1; e.pcsrc = 2'b01; end
                default:    begin e.a = 1; e.b = 2'b01; e.pcw = 1; e.care_pcsrc = 1; e.pcsrc = 2'b10; end
            endcase
            pushCycle(e, 1'b1);
        end
        if (!done && (is_ld || is_st)) begin
            reqPhase(3, mwait, is_st, is_st, to);
            done = to || is_st;
        end
        if (!done) begin
            e = base(4);
            e.rw = 1; e.ret = 1; e.care_mtor = 1;
            e.mtor = is_ld ? 2'b01 : (op == OPC_JAL || op == OPC_JALR) ? 2'b10 : 2'b00;
            pushCycle(e, 1'b1);
        end
        sched_len = sched_q.size();
        n = (cut > 0) ? cut : sched_len;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = rdy_q[i];
            exp_q.push_back(sched_q[i]);
            if (i < n - 1 || cut == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic runCpi(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic f75, input logic [2:0] zll, input int fwait,
                          input int mwait, input int cpi);
        applyStimulus(name, op, f3, f75, zll, fwait, mwait, 0);
        checkOutput("cpi", last_cpi, cpi);
        checkOutput("sched_len", sched_len, cpi);
    endtask

    task automatic doReset();
        cur_name = "reset";
        reset = 1'b1;
        @(negedge clk);
        checkOutput("stage", bus.current_stage, 0);
        checkOutput("strobes", {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite,
                                bus.RegWrite, bus.instr_retired}, 0);
        checkOutput("flags", {bus.illegal_instr, bus.bus_error}, 0);
        checkOutput("muxes", {bus.MtoR, bus.AluSrcA, bus.AluSrcB, bus.PCSrc}, 0);
        checkOutput("alu_op", bus.alu_op, ALU_ADD);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Per-cycle comparison against the expected schedule plus CPI measurement.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checkOutput("stage", bus.current_stage, cur.stage);
            checkOutput("strobes", {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite,
                                    bus.RegWrite, bus.instr_retired},
                        {cur.pcw, cur.irw, cur.mr, cur.mw, cur.rw, cur.ret});
            checkOutput("flags", {bus.illegal_instr, bus.bus_error}, {cur.ill, cur.berr});
            if (cur.care_a)     checkOutput("AluSrcA", bus.AluSrcA, cur.a);
            if (cur.care_b)     checkOutput("AluSrcB", bus.AluSrcB, cur.b);
            if (cur.care_mtor)  checkOutput("MtoR", bus.MtoR, cur.mtor);
            if (cur.care_pcsrc) checkOutput("PCSrc", bus.PCSrc, cur.pcsrc);
            if (cur.care_alu)   checkOutput("alu_op", bus.alu_op, cur.alu);
        end
        if (reset) begin
            cyc_cnt = 0;
        end else if (bus.instr_retired) begin
            last_cpi = cyc_cnt + 1;
            cyc_cnt = 0;
        end else begin
            cyc_cnt++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.opcode = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7_5 = 1'b0;
        bus.zero = 1'b0;
        bus.lt = 1'b0;
        bus.ltu = 1'b0;
        bus.mem_ready = 1'b0;
        doReset();

        runCpi("add",      OPC_R,      3'd0, 1'b0, 3'b000, 0, 0, 4);
        runCpi("sub_fw2",  OPC_R,      3'd0, 1'b1, 3'b000, 2, 0, 6);
        runCpi("srai",     OPC_I,      3'd5, 1'b1, 3'b000, 0, 0, 4);
        runCpi("lw_w3",    OPC_LOAD,   3'd2, 1'b0, 3'b000, 0, 3, 8);
        runCpi("sw_w4",    OPC_STORE,  3'd2, 1'b0, 3'b000, 0, 4, 8);
        runCpi("beq_t",    OPC_BRANCH, 3'd0, 1'b0, 3'b100, 0, 0, 3);
        runCpi("beq_nt",   OPC_BRANCH, 3'd0, 1'b0, 3'b000, 0, 0, 3);
        runCpi("bltu_t",   OPC_BRANCH, 3'd6, 1'b0, 3'b001, 0, 0, 3);
        runCpi("bge_nt",   OPC_BRANCH, 3'd5, 1'b0, 3'b010, 0, 0, 3);
        runCpi("lui",      OPC_LUI,    3'd0, 1'b0, 3'b000, 0, 0, 4);
        runCpi("auipc",    OPC_AUIPC,  3'd0, 1'b0, 3'b000, 0, 0, 4);
        runCpi("jal",      OPC_JAL,    3'd0, 1'b0, 3'b000, 0, 0, 4);
        runCpi("jalr",     OPC_JALR,   3'd0, 1'b0, 3'b000, 1, 0, 5);

        applyStimulus("fetch_tmo", OPC_R, 3'd0, 1'b0, 3'b000, 20, 0, 0);
        checkOutput("halt_stage", bus.current_stage, 5);
        checkOutput("bus_error", bus.bus_error, 1);
        doReset();

        applyStimulus("lw_tmo", OPC_LOAD, 3'd2, 1'b0, 3'b000, 0, 9, 0);
        checkOutput("bus_error", bus.bus_error, 1);
        doReset();

        applyStimulus("op_7f", 7'h7F, 3'd0, 1'b0, 3'b000, 0, 0, 0);
        checkOutput("illegal_instr", bus.illegal_instr, 1);
        checkOutput("halt_stage", bus.current_stage, 5);
        doReset();

        applyStimulus("system", 7'b1110011, 3'd0, 1'b0, 3'b000, 0, 0, 0);
        checkOutput("illegal_instr", bus.illegal_instr, 1);
        doReset();

        applyStimulus("add_rst_wb", OPC_R, 3'd0, 1'b0, 3'b000, 0, 0, 4);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_RegWrite", bus.RegWrite, 0);
        checkOutput("async_stage", bus.current_stage, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        runCpi("add_after", OPC_R, 3'd7, 1'b0, 3'b000, 0, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
